// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode and funct constants,
// the FSM state encoding, ALUOp encodings and datapath mux select encodings.
package mips_mc_pkg;

   // Instruction opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // 3-bit ALU operation codes, zero-extended to the configured width
   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

   // FSM states; encodings are visible on state_dbg
   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StRtypeEx = 4'd6,
      StRtypeWb = 4'd7,
      StBeqEx   = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJumpEx  = 4'd11,
      StBneEx   = 4'd12
   } state_e;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10
   } alu_op_e;

   // ALU B operand select
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decoder.
// Ports:
//   alu_op_i        ALUOp from the FSM (add / sub / use funct)
//   funct_i         instr[5:0]
//   alu_control_o   ALU operation, ALUCTL_W bits (3-bit code zero-extended)
//   funct_illegal_o high when ALUOp selects funct and the funct is unsupported
module mc_alu_decoder
   import mips_mc_pkg::*;
#(
   parameter int unsigned ALUCTL_W = 3
) (
   input  alu_op_e             alu_op_i,
   input  logic [5:0]          funct_i,
   output logic [ALUCTL_W-1:0] alu_control_o,
   output logic                funct_illegal_o
);

   logic [2:0] code;

   always_comb begin
      code            = ALUC_ADD;
      funct_illegal_o = 1'b0;
      case (alu_op_i)
         AluOpSub: code = ALUC_SUB;
         AluOpFunct: begin
            case (funct_i)
               FN_ADD:  code = ALUC_ADD;
               FN_SUB:  code = ALUC_SUB;
               FN_AND:  code = ALUC_AND;
               FN_OR:   code = ALUC_OR;
               FN_SLT:  code = ALUC_SLT;
               default: begin
                  // Unknown funct still produces a harmless add
                  code            = ALUC_ADD;
                  funct_illegal_o = 1'b1;
               end
            endcase
         end
         default: code = ALUC_ADD;
      endcase
   end

   assign alu_control_o = ALUCTL_W'(code);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode, execute, memory and
// writeback, driving the shared-memory / shared-ALU datapath muxes and enables.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   opcode, funct     fields from the instruction register
//   zero              ALU zero flag (branch resolution)
//   mem_ready         memory access completes this cycle
//   iord .. pcen      datapath selects and enables
//   alu_control       ALU operation (ALUCTL_W bits)
//   illegal           sticky unsupported opcode/funct flag, cleared only by reset
//   state_dbg         current state encoding
module mips_multicycle_control
   import mips_mc_pkg::*;
#(
   parameter int unsigned ALUCTL_W = 3,
   parameter bit          EN_ADDI  = 1'b1,
   parameter bit          EN_BNE   = 1'b1,
   parameter bit          EN_JUMP  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                iord,
   output logic                irwrite,
   output logic                mem_req,
   output logic                memwrite,
   output logic                regwrite,
   output logic                regdst,
   output logic                memtoreg,
   output logic                alusrca,
   output logic [1:0]          alusrcb,
   output logic [1:0]          pcsrc,
   output logic                pcen,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic                illegal,
   output logic [3:0]          state_dbg
);

   state_e  state_q, state_d;
   logic    illegal_q, illegal_d;
   logic    illegal_dec;
   logic    funct_illegal;
   logic    pcwrite;
   logic    branch_eq, branch_ne;
   alu_op_e alu_op;

   mc_alu_decoder #(
      .ALUCTL_W (ALUCTL_W)
   ) u_alu_decoder (
      .alu_op_i        (alu_op),
      .funct_i         (funct),
      .alu_control_o   (alu_control),
      .funct_illegal_o (funct_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // funct_illegal can only assert in RTYPEEX, the only state selecting AluOpFunct
   assign illegal_d = illegal_q | illegal_dec | funct_illegal;
   assign illegal   = illegal_q;
   assign state_dbg = state_q;

   always_comb begin
      state_d     = state_q;
      illegal_dec = 1'b0;
      iord        = 1'b0;
      irwrite     = 1'b0;
      mem_req     = 1'b0;
      memwrite    = 1'b0;
      regwrite    = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = SRCB_RT;
      pcsrc       = PCSRC_ALU;
      pcwrite     = 1'b0;
      alu_op      = AluOpAdd;
      branch_eq   = 1'b0;
      branch_ne   = 1'b0;

      case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            alusrcb = SRCB_IMM_SH2;
            state_d = StFetch;
            case (opcode)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_RTYPE:     state_d = StRtypeEx;
               OP_BEQ:       state_d = StBeqEx;
               OP_BNE: begin
                  if (EN_BNE) state_d = StBneEx;
                  else        illegal_dec = 1'b1;
               end
               OP_ADDI: begin
                  if (EN_ADDI) state_d = StAddiEx;
                  else         illegal_dec = 1'b1;
               end
               OP_J: begin
                  if (EN_JUMP) state_d = StJumpEx;
                  else         illegal_dec = 1'b1;
               end
               default: illegal_dec = 1'b1;
            endcase
         end
         StMemAdr: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
         end
         StMemRd: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWr: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = mem_ready;
            if (mem_ready) state_d = StFetch;
         end
         StMemWb: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            state_d  = StFetch;
         end
         StRtypeEx: begin
            alusrca = 1'b1;
            alu_op  = AluOpFunct;
            state_d = StRtypeWb;
         end
         StRtypeWb: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_d  = StFetch;
         end
         StAddiEx: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            state_d = StAddiWb;
         end
         StAddiWb: begin
            regwrite = 1'b1;
            state_d  = StFetch;
         end
         StBeqEx: begin
            alusrca   = 1'b1;
            alu_op    = AluOpSub;
            pcsrc     = PCSRC_ALUOUT;
            branch_eq = 1'b1;
            state_d   = StFetch;
         end
         StBneEx: begin
            alusrca   = 1'b1;
            alu_op    = AluOpSub;
            pcsrc     = PCSRC_ALUOUT;
            branch_ne = 1'b1;
            state_d   = StFetch;
         end
         StJumpEx: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
            state_d = StFetch;
         end
         default: state_d = StFetch;  // unreachable encodings recover
      endcase

      pcen = pcwrite | (branch_eq & zero) | (branch_ne & ~zero);

      // Async reset parks the FSM in FETCH, which would otherwise request memory
      if (rst) begin
         irwrite  = 1'b0;
         pcen     = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         mem_req  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;
   import mips_mc_pkg::*;

   logic       clk, rst;
   logic [5:0] opcode, funct, opcode_b;
   logic       zero, mem_ready, mem_ready_b;

   logic       iord, irwrite, mem_req, memwrite, regwrite, regdst, memtoreg, alusrca, pcen;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alu_control;
   logic       illegal;
   logic [3:0] state_dbg;

   logic       b_iord, b_irwrite, b_mem_req, b_memwrite, b_regwrite, b_regdst, b_memtoreg;
   logic       b_alusrca, b_pcen, b_illegal;
   logic [1:0] b_alusrcb, b_pcsrc;
   logic [2:0] b_alu_control;
   logic [3:0] b_state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   mips_multicycle_control #(
      .ALUCTL_W (3), .EN_ADDI (1'b1), .EN_BNE (1'b1), .EN_JUMP (1'b1)
   ) u_dut (
      .clk (clk), .rst (rst), .opcode (opcode), .funct (funct), .zero (zero),
      .mem_ready (mem_ready), .iord (iord), .irwrite (irwrite), .mem_req (mem_req),
      .memwrite (memwrite), .regwrite (regwrite), .regdst (regdst), .memtoreg (memtoreg),
      .alusrca (alusrca), .alusrcb (alusrcb), .pcsrc (pcsrc), .pcen (pcen),
      .alu_control (alu_control), .illegal (illegal), .state_dbg (state_dbg)
   );

   mips_multicycle_control #(
      .ALUCTL_W (3), .EN_ADDI (1'b1), .EN_BNE (1'b0), .EN_JUMP (1'b1)
   ) u_dut_nobne (
      .clk (clk), .rst (rst), .opcode (opcode_b), .funct (funct), .zero (zero),
      .mem_ready (mem_ready_b), .iord (b_iord), .irwrite (b_irwrite), .mem_req (b_mem_req),
      .memwrite (b_memwrite), .regwrite (b_regwrite), .regdst (b_regdst),
      .memtoreg (b_memtoreg), .alusrca (b_alusrca), .alusrcb (b_alusrcb), .pcsrc (b_pcsrc),
      .pcen (b_pcen), .alu_control (b_alu_control), .illegal (b_illegal),
      .state_dbg (b_state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle on the main DUT: drive at negedge, settle, caller samples
   task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy);
      @(negedge clk);
      opcode    = op;
      funct     = fn;
      zero      = z;
      mem_ready = rdy;
      #1;
   endtask

   task automatic cyc_b(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
      @(negedge clk);
      opcode_b    = op;
      funct       = fn;
      mem_ready_b = rdy;
      #1;
   endtask

   int lw_st  [9] = '{0, 0, 0, 1, 2, 3, 3, 4, 0};
   int lw_rdy [9] = '{0, 0, 1, 1, 1, 0, 1, 1, 0};
   int rt_st  [4] = '{0, 1, 6, 7};

   initial begin
      rst = 1'b1; opcode = 6'h0; funct = 6'h0; zero = 1'b0; mem_ready = 1'b1;
      opcode_b = 6'h0; mem_ready_b = 1'b1;
      #12;
      check_eq("rst_state", 32'(state_dbg), 32'd0);
      check_eq("rst_mem_req", 32'(mem_req), 32'd0);
      check_eq("rst_irwrite", 32'(irwrite), 32'd0);
      check_eq("rst_pcen", 32'(pcen), 32'd0);
      check_eq("rst_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0; mem_ready_b = 1'b0;

      // LW with fetch and read wait states
      for (int i = 0; i < 9; i++) begin
         cyc(OP_LW, 6'h0, 1'b0, 1'(lw_rdy[i]));
         check_eq("lw_state", 32'(state_dbg), 32'(lw_st[i]));
         check_eq("lw_irwrite", 32'(irwrite), 32'(i == 2));
         check_eq("lw_pcen", 32'(pcen), 32'(i == 2));
         if (i == 5) begin
            check_eq("lw_rd_mem_req", 32'(mem_req), 32'd1);
            check_eq("lw_rd_iord", 32'(iord), 32'd1);
         end
         if (i == 7) begin
            check_eq("lw_wb_regwrite", 32'(regwrite), 32'd1);
            check_eq("lw_wb_memtoreg", 32'(memtoreg), 32'd1);
            check_eq("lw_wb_regdst", 32'(regdst), 32'd0);
         end
      end

      // R-type AND
      for (int i = 0; i < 4; i++) begin
         cyc(OP_RTYPE, FN_AND, 1'b0, 1'b1);
         check_eq("and_state", 32'(state_dbg), 32'(rt_st[i]));
         if (i == 2) begin
            check_eq("and_alu_control", 32'(alu_control), 32'b000);
            check_eq("and_alusrca", 32'(alusrca), 32'd1);
            check_eq("and_alusrcb", 32'(alusrcb), 32'b00);
         end
         if (i == 3) begin
            check_eq("and_regwrite", 32'(regwrite), 32'd1);
            check_eq("and_regdst", 32'(regdst), 32'd1);
            check_eq("and_memtoreg", 32'(memtoreg), 32'd0);
         end
      end
      cyc(OP_RTYPE, FN_AND, 1'b0, 1'b0);
      check_eq("and_back_fetch", 32'(state_dbg), 32'd0);

      // BEQ taken
      cyc(OP_BEQ, 6'h0, 1'b1, 1'b1);
      cyc(OP_BEQ, 6'h0, 1'b1, 1'b1);
      cyc(OP_BEQ, 6'h0, 1'b1, 1'b0);
      check_eq("beq_state", 32'(state_dbg), 32'd8);
      check_eq("beq_pcen", 32'(pcen), 32'd1);
      check_eq("beq_pcsrc", 32'(pcsrc), 32'b01);
      check_eq("beq_alu_control", 32'(alu_control), 32'b110);
      cyc(OP_BEQ, 6'h0, 1'b1, 1'b0);
      check_eq("beq_back_fetch", 32'(state_dbg), 32'd0);

      // BNE with zero=1 (not taken) then zero=0 (taken)
      for (int z = 1; z >= 0; z--) begin
         cyc(OP_BNE, 6'h0, 1'(z), 1'b1);
         cyc(OP_BNE, 6'h0, 1'(z), 1'b1);
         cyc(OP_BNE, 6'h0, 1'(z), 1'b0);
         check_eq("bne_state", 32'(state_dbg), 32'd12);
         check_eq("bne_pcen", 32'(pcen), 32'(z == 0));
         check_eq("bne_pcsrc", 32'(pcsrc), 32'b01);
         cyc(OP_BNE, 6'h0, 1'(z), 1'b0);
         check_eq("bne_back_fetch", 32'(state_dbg), 32'd0);
      end

      // Jump
      cyc(OP_J, 6'h0, 1'b0, 1'b1);
      cyc(OP_J, 6'h0, 1'b0, 1'b1);
      cyc(OP_J, 6'h0, 1'b0, 1'b0);
      check_eq("j_state", 32'(state_dbg), 32'd11);
      check_eq("j_pcsrc", 32'(pcsrc), 32'b10);
      check_eq("j_pcen", 32'(pcen), 32'd1);

      // ADDI
      cyc(OP_ADDI, 6'h0, 1'b0, 1'b1);
      cyc(OP_ADDI, 6'h0, 1'b0, 1'b1);
      cyc(OP_ADDI, 6'h0, 1'b0, 1'b1);
      check_eq("addi_ex_state", 32'(state_dbg), 32'd9);
      check_eq("addi_ex_alusrcb", 32'(alusrcb), 32'b10);
      check_eq("addi_ex_alusrca", 32'(alusrca), 32'd1);
      cyc(OP_ADDI, 6'h0, 1'b0, 1'b0);
      check_eq("addi_wb_state", 32'(state_dbg), 32'd10);
      check_eq("addi_wb_regwrite", 32'(regwrite), 32'd1);
      check_eq("addi_wb_regdst", 32'(regdst), 32'd0);
      check_eq("legal_no_illegal", 32'(illegal), 32'd0);

      // SW completing in one memory cycle
      cyc(OP_SW, 6'h0, 1'b0, 1'b1);
      cyc(OP_SW, 6'h0, 1'b0, 1'b1);
      cyc(OP_SW, 6'h0, 1'b0, 1'b1);
      cyc(OP_SW, 6'h0, 1'b0, 1'b1);
      check_eq("sw_state", 32'(state_dbg), 32'd5);
      check_eq("sw_memwrite", 32'(memwrite), 32'd1);
      check_eq("sw_iord", 32'(iord), 32'd1);
      cyc(OP_SW, 6'h0, 1'b0, 1'b0);
      check_eq("sw_back_fetch", 32'(state_dbg), 32'd0);

      // Unsupported funct
      cyc(OP_RTYPE, 6'h03, 1'b0, 1'b1);
      cyc(OP_RTYPE, 6'h03, 1'b0, 1'b1);
      cyc(OP_RTYPE, 6'h03, 1'b0, 1'b1);
      check_eq("badfn_alu_control", 32'(alu_control), 32'b010);
      cyc(OP_RTYPE, 6'h03, 1'b0, 1'b0);
      check_eq("badfn_illegal", 32'(illegal), 32'd1);
      cyc(OP_RTYPE, 6'h03, 1'b0, 1'b0);
      check_eq("badfn_illegal_sticky", 32'(illegal), 32'd1);

      // BNE on the instance built without BNE support
      cyc_b(OP_BNE, 6'h0, 1'b1);
      cyc_b(OP_BNE, 6'h0, 1'b1);
      check_eq("nobne_decode", 32'(b_state_dbg), 32'd1);
      check_eq("nobne_illegal_pre", 32'(b_illegal), 32'd0);
      cyc_b(OP_BNE, 6'h0, 1'b0);
      check_eq("nobne_to_fetch", 32'(b_state_dbg), 32'd0);
      check_eq("nobne_illegal", 32'(b_illegal), 32'd1);
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) begin
            cyc_b(OP_RTYPE, FN_ADD, 1'b1);
            check_eq("nobne_rt_state", 32'(b_state_dbg), 32'(rt_st[i]));
         end
         check_eq("nobne_illegal_sticky", 32'(b_illegal), 32'd1);
      end
      cyc_b(OP_RTYPE, FN_ADD, 1'b0);
      check_eq("nobne_final_fetch", 32'(b_state_dbg), 32'd0);

      // Reset while MEMWR waits for memory
      cyc(OP_SW, 6'h0, 1'b0, 1'b1);
      cyc(OP_SW, 6'h0, 1'b0, 1'b1);
      cyc(OP_SW, 6'h0, 1'b0, 1'b1);
      cyc(OP_SW, 6'h0, 1'b0, 1'b0);
      check_eq("wr_wait_state", 32'(state_dbg), 32'd5);
      check_eq("wr_wait_memwrite", 32'(memwrite), 32'd0);
      #2;
      rst       = 1'b1;
      mem_ready = 1'b1;
      #1;
      check_eq("arst_state", 32'(state_dbg), 32'd0);
      check_eq("arst_memwrite", 32'(memwrite), 32'd0);
      check_eq("arst_mem_req", 32'(mem_req), 32'd0);
      check_eq("arst_irwrite", 32'(irwrite), 32'd0);
      check_eq("arst_illegal", 32'(illegal), 32'd0);
      check_eq("arst_illegal_b", 32'(b_illegal), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = 1'b0;
      cyc(OP_LW, 6'h0, 1'b0, 1'b1);
      check_eq("post_rst_state", 32'(state_dbg), 32'd0);
      check_eq("post_rst_irwrite", 32'(irwrite), 32'd1);
      check_eq("post_rst_pcen", 32'(pcen), 32'd1);
      check_eq("post_rst_mem_req", 32'(mem_req), 32'd1);
      cyc(OP_LW, 6'h0, 1'b0, 1'b1);
      check_eq("post_rst_decode", 32'(state_dbg), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit: a Moore FSM sequencing fetch, decode, execute, memory and writeback over several cycles, so one shared memory and one ALU serve the whole datapath.
- Generalised ALU-control width, optional BNE/ADDI/J support, a memory wait-state handshake, and sticky illegal-opcode detection.
- Sits between the instruction register (opcode/funct) and the multi-cycle datapath muxes and enables.

Parameters:
- ALUCTL_W, 3: width of alu_control.
- EN_ADDI, 1: when 1, decode ADDI (opcode 0x08); when 0, ADDI is illegal.
- EN_BNE, 1: when 1, decode BNE (opcode 0x05); when 0, BNE is illegal.
- EN_JUMP, 1: when 1, decode J (opcode 0x02); when 0, J is illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  instruction register load.
- mem_req  out  1  memory access valid.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write enable.
- regdst  out  1  write register select: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback select: 1 = data register.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = signext, 11 = signext<<2.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC write enable.
- alu_control  out  ALUCTL_W  ALU operation.
- illegal  out  1  sticky unsupported-opcode/funct flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JUMPEX=11, BNEEX=12.
- Transitions:
  - FETCH -> DECODE only when mem_ready=1; otherwise hold FETCH. Outputs are held stable during the wait, and irwrite and pcwrite assert only on the mem_ready cycle.
  - DECODE branches on opcode: LW/SW -> MEMADR; R-type (0x00) -> RTYPEEX; BEQ -> BEQEX; BNE -> BNEEX; ADDI -> ADDIEX; J -> JUMPEX.
  - DECODE with any other opcode, or an opcode whose EN_* parameter is 0 -> FETCH, and sets illegal.
  - MEMADR -> MEMRD for LW, MEMWR for SW.
  - MEMRD and MEMWR hold until mem_ready=1. MEMRD then -> MEMWB; MEMWR then -> FETCH.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, BNEEX and JUMPEX -> FETCH. RTYPEEX -> RTYPEWB. ADDIEX -> ADDIWB.
- Outputs are decoded from the current state only (Moore). Any signal not listed for a state is 0:
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, ALUOp=add, pcsrc=00; irwrite and pcwrite = mem_ready.
  - DECODE: alusrca=0, alusrcb=11, ALUOp=add.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, ALUOp=add.
  - MEMRD: mem_req=1, iord=1.
  - MEMWR: mem_req=1, iord=1, memwrite=mem_ready.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1.
  - RTYPEEX: alusrca=1, alusrcb=00, ALUOp=funct.
  - RTYPEWB: regwrite=1, regdst=1, memtoreg=0.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0.
  - BEQEX and BNEEX: alusrca=1, alusrcb=00, ALUOp=sub, pcsrc=01.
  - JUMPEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (BEQEX & zero) | (BNEEX & ~zero).
- ALU decode, 3-bit default encoding:
  - ALUOp add -> 010; sub -> 110.
  - funct 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111.
  - Any other funct in RTYPEEX -> 010, and sets illegal.
  - Codes are zero-extended to ALUCTL_W.
- Reset:
  - rst asserted at any time, including mid-memory-wait, forces state=FETCH and illegal=0 immediately.
  - While rst=1, irwrite, pcen, memwrite, regwrite and mem_req are forced to 0.
- illegal clears only on reset.
- An unreachable state encoding -> FETCH on the next clock.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - funct constants;
  - the state enum (4-bit);
  - ALUOp encodings (ADD=00, SUB=01, FUNCT=10);
  - alusrcb and pcsrc select encodings.
- One sub-module, mc_alu_decoder, is combinational: ALUOp + funct -> alu_control and funct_illegal, parametrised by ALUCTL_W.
- The FSM and output decode stay in the top module.

Test Plan:
- LW (opcode 0x23), mem_ready low 2 cycles in FETCH and 1 cycle in MEMRD:
  - required state sequence 0,0,0,1,2,3,3,4,0;
  - irwrite and pcen high only in the third FETCH cycle;
  - regwrite=1 and memtoreg=1 in MEMWB.
- R-type AND (funct 0x24): alu_control=000 in RTYPEEX; regwrite=1 and regdst=1 in RTYPEWB; total 4 cycles with mem_ready=1.
- BEQ with zero=1 -> pcen=1, pcsrc=01 in BEQEX. BNE with zero=1 -> pcen=0. BNE with zero=0 -> pcen=1.
- EN_BNE=0, opcode 0x05 -> DECODE goes to FETCH; illegal=1 and stays set across 5 further instructions.
- R-type funct 0x03 -> alu_control=010 and illegal=1.
- rst pulse while in MEMWR with mem_ready=0:
  - state_dbg=0 and memwrite=0 immediately, without waiting for a clock edge;
  - illegal=0;
  - after release, FETCH resumes normally.
